// File: rtl/uart_telemetry_framer_pkg.sv
// Shared types and helpers for the telemetry framer: FSM states, ASCII
// framing characters and nibble-to-hex conversion.
package telemetry_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SOF    = 3'd1,
    SEQ_HI = 3'd2,
    SEQ_LO = 3'd3,
    SEP    = 3'd4,
    DIG    = 3'd5,
    CR     = 3'd6,
    LF     = 3'd7
  } state_e;

  localparam logic [7:0] ASCII_SOF = 8'h24;
  localparam logic [7:0] ASCII_SEP = 8'h2C;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  // Uppercase hex digit: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else begin
      c = 8'h37 + {4'h0, nib};
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_telemetry_framer_if.sv
// Byte-stream valid/ready link from the framer to the UART transmitter.
interface uart_telemetry_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_telemetry_framer_period_timer.sv
// Free-running frame period timer: counts 0..PERIOD_CYCLES-1, flags the last
// count as tick and exposes one timer bit as the heartbeat LED.
module period_timer #(
  parameter int PERIOD_CYCLES = 12_500_000,
  parameter int HB_BIT        = 23
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic heartbeat
);

  localparam int TW = $clog2(PERIOD_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(PERIOD_CYCLES - 1);

  logic [TW-1:0] timer_r;

  assign tick      = (timer_r == LAST);
  assign heartbeat = timer_r[HB_BIT];

  // Period counter with wrap on the last count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_r <= '0;
    end else if (tick) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

endmodule

// File: rtl/uart_telemetry_framer.sv
// Snapshots NUM_CH channels on a periodic tick or trigger and streams them to
// the UART as "$[SS,]HH..,HH..\r\n" with registered valid/ready outputs.
module uart_telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 8,
  parameter int PERIOD_CYCLES = 12_500_000,
  parameter int SEQ_EN        = 1,
  parameter int HB_BIT        = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     trig,
  uart_telemetry_framer_if.master  tx,
  output logic                     busy,
  output logic                     overrun,
  output logic                     heartbeat,
  output logic [7:0]               seq
);

  localparam int NDIG  = (DATA_W + 3) / 4;
  localparam int PAD_W = NDIG * 4;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NIB_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NDIG - 1);

  state_e                     state_r, state_s;
  logic [CH_W-1:0]            ch_r, ch_s;
  logic [NIB_W-1:0]           nib_r, nib_s;
  logic [7:0]                 seq_r, seq_s;
  logic [NUM_CH*DATA_W-1:0]   snap_r;
  logic [7:0]                 tx_data_r, byte_s;
  logic                       tx_valid_r, busy_r, overrun_r;
  logic                       tick_s, req_s, adv_s, snap_load_s, overrun_s;
  logic [DATA_W-1:0]          chan_s;
  logic [PAD_W-1:0]           pad_s;
  logic [3:0]                 nib_val_s;

  period_timer #(
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .HB_BIT        (HB_BIT)
  ) u_period_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick_s),
    .heartbeat (heartbeat)
  );

  assign req_s = tick_s | trig;
  assign adv_s = tx_valid_r & tx.tx_ready;

  // Next-state, counter and overrun logic; everything holds while stalled
  always_comb begin
    state_s     = state_r;
    ch_s        = ch_r;
    nib_s       = nib_r;
    seq_s       = seq_r;
    snap_load_s = 1'b0;
    overrun_s   = req_s && (state_r != IDLE);
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_s     = SOF;
          snap_load_s = 1'b1;
          ch_s        = '0;
          nib_s       = '0;
        end else begin
          state_s = IDLE;
        end
      end
      SOF: begin
        if (adv_s) begin
          if (SEQ_EN != 0) begin
            state_s = SEQ_HI;
          end else begin
            state_s = DIG;
          end
        end else begin
          state_s = SOF;
        end
      end
      SEQ_HI: begin
        if (adv_s) state_s = SEQ_LO;
        else       state_s = SEQ_HI;
      end
      SEQ_LO: begin
        if (adv_s) state_s = SEP;
        else       state_s = SEQ_LO;
      end
      SEP: begin
        if (adv_s) begin
          state_s = DIG;
          nib_s   = '0;
        end else begin
          state_s = SEP;
        end
      end
      DIG: begin
        if (adv_s) begin
          if (nib_r == LAST_NIB) begin
            nib_s = '0;
            if (ch_r == LAST_CH) begin
              state_s = CR;
            end else begin
              ch_s    = ch_r + CH_W'(1);
              state_s = SEP;
            end
          end else begin
            nib_s = nib_r + NIB_W'(1);
          end
        end else begin
          state_s = DIG;
        end
      end
      CR: begin
        if (adv_s) state_s = LF;
        else       state_s = CR;
      end
      LF: begin
        if (adv_s) begin
          state_s = IDLE;
          seq_s   = seq_r + 8'd1;
        end else begin
          state_s = LF;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Byte for the state being entered; the MSB nibble of each channel goes first
  always_comb begin
    chan_s    = snap_r[int'(ch_s) * DATA_W +: DATA_W];
    pad_s     = '0;
    pad_s[DATA_W-1:0] = chan_s;
    nib_val_s = pad_s[(NDIG - 1 - int'(nib_s)) * 4 +: 4];
    case (state_s)
      SOF:     byte_s = ASCII_SOF;
      SEQ_HI:  byte_s = nibble_to_ascii(seq_r[7:4]);
      SEQ_LO:  byte_s = nibble_to_ascii(seq_r[3:0]);
      SEP:     byte_s = ASCII_SEP;
      DIG:     byte_s = nibble_to_ascii(nib_val_s);
      CR:      byte_s = ASCII_CR;
      LF:      byte_s = ASCII_LF;
      default: byte_s = 8'h00;
    endcase
  end

  // State, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ch_r       <= '0;
      nib_r      <= '0;
      seq_r      <= 8'd0;
      snap_r     <= '0;
      tx_data_r  <= 8'd0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      ch_r       <= ch_s;
      nib_r      <= nib_s;
      seq_r      <= seq_s;
      if (snap_load_s) begin
        snap_r <= ch_data;
      end else begin
        snap_r <= snap_r;
      end
      tx_data_r  <= byte_s;
      tx_valid_r <= (state_s != IDLE);
      busy_r     <= (state_s != IDLE);
      overrun_r  <= overrun_s;
    end
  end

  assign tx.tx_data  = tx_data_r;
  assign tx.tx_valid = tx_valid_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;
  assign seq         = seq_r;

endmodule

// File: tb/tb_uart_telemetry_framer.sv
// Randomised bench for uart_telemetry_framer: a queue-based frame model for the
// 2x8-bit sequenced instance plus directed frame checks on a 3x10-bit instance.
module tb_uart_telemetry_framer;

  localparam int A_NCH = 2, A_DW = 8,  A_P = 64,     A_HB = 5;
  localparam int B_NCH = 3, B_DW = 10, B_P = 100000, B_HB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ch_a;
  logic [29:0] ch_b;
  logic        trig_a, trig_b;
  logic        busy_a, ovr_a, hb_a, busy_b, ovr_b, hb_b;
  logic [7:0]  seq_a, seq_b;

  uart_telemetry_framer_if ifa ();
  uart_telemetry_framer_if ifb ();

  always #5 clk = ~clk;

  uart_telemetry_framer #(.NUM_CH(A_NCH), .DATA_W(A_DW), .PERIOD_CYCLES(A_P),
                          .SEQ_EN(1), .HB_BIT(A_HB)) dut_a (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_a), .trig(trig_a), .tx(ifa),
    .busy(busy_a), .overrun(ovr_a), .heartbeat(hb_a), .seq(seq_a));

  uart_telemetry_framer #(.NUM_CH(B_NCH), .DATA_W(B_DW), .PERIOD_CYCLES(B_P),
                          .SEQ_EN(0), .HB_BIT(B_HB)) dut_b (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_b), .trig(trig_b), .tx(ifb),
    .busy(busy_b), .overrun(ovr_b), .heartbeat(hb_b), .seq(seq_b));

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state for instance A
  int         m_timer;
  logic [7:0] mq[$];
  logic [7:0] m_seq;
  logic       m_ovr;

  bit    rnd_a, rnd_b, per_mode;
  string cap_a, cap_b, crlf;
  int    cyc, base_cyc, last_start, n_starts, ovr_cnt_a;
  logic  prev_busy_a, b_hold_v;
  logic [7:0] b_hold_d;

  function automatic logic [7:0] hexc(input int v);
    if (v < 10) return 8'(48 + v);
    else        return 8'(55 + v);
  endfunction

  function automatic string make_frame(input int nch, input int dw, input bit seq_en,
                                       input logic [63:0] data, input logic [7:0] s);
    string f;
    int nd;
    logic [63:0] v;
    nd = (dw + 3) / 4;
    f  = "$";
    if (seq_en) f = {f, $sformatf("%c%c,", hexc(int'(s) / 16), hexc(int'(s) % 16))};
    for (int ch = 0; ch < nch; ch++) begin
      v = (data >> (ch * dw)) & ((64'd1 << dw) - 64'd1);
      for (int d = nd - 1; d >= 0; d--) begin
        f = {f, $sformatf("%c", hexc(int'((v >> (4 * d)) & 64'd15)))};
      end
      if (ch < nch - 1) f = {f, ","};
    end
    return {f, $sformatf("%c%c", 8'h0D, 8'h0A)};
  endfunction

  task automatic model_step();
    bit    req;
    string f;
    if (!rst_n) begin
      m_timer = 0; mq.delete(); m_seq = 8'd0; m_ovr = 1'b0;
      return;
    end
    req   = (m_timer == A_P - 1) || trig_a;
    m_ovr = 1'b0;
    if (mq.size() > 0) begin
      if (req) m_ovr = 1'b1;
      if (ifa.tx_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_seq = m_seq + 8'd1;
      end
    end else if (req) begin
      f = make_frame(A_NCH, A_DW, 1'b1, {48'h0, ch_a}, m_seq);
      for (int i = 0; i < f.len(); i++) mq.push_back(f[i]);
    end
    m_timer = (m_timer == A_P - 1) ? 0 : m_timer + 1;
  endtask

  task automatic cycle();
    ifa.tx_ready = rnd_a ? 1'($urandom_range(0, 1)) : 1'b1;
    ifb.tx_ready = rnd_b ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst_n && ifa.tx_valid && ifa.tx_ready) cap_a = {cap_a, $sformatf("%c", ifa.tx_data)};
    if (rst_n && ifb.tx_valid && ifb.tx_ready) cap_b = {cap_b, $sformatf("%c", ifb.tx_data)};
    b_hold_v = rst_n && ifb.tx_valid && !ifb.tx_ready;
    b_hold_d = ifb.tx_data;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("a_valid", ifa.tx_valid, mq.size() > 0);
    chk("a_busy", busy_a, mq.size() > 0);
    if (mq.size() > 0) chk("a_data", ifa.tx_data, mq[0]);
    chk("a_ovr", ovr_a, m_ovr);
    chk("a_seq", seq_a, m_seq);
    chk("a_hb", hb_a, (m_timer >> A_HB) & 1);
    chk("b_hb", hb_b, 0);
    chk("b_ovr", ovr_b, 0);
    if (b_hold_v) chk("b_hold", {ifb.tx_valid, ifb.tx_data}, {1'b1, b_hold_d});
    if (ovr_a) ovr_cnt_a++;
    if (busy_a && !prev_busy_a) begin
      if (per_mode) begin
        if (n_starts == 0) chk("a_first", cyc - base_cyc, 64);
        else               chk("a_period", cyc - last_start, 64);
      end
      n_starts++;
      last_start = cyc;
    end
    prev_busy_a = busy_a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trig_a = 1'b0; trig_b = 1'b0;
    cycle();
    rst_n = 1'b1;
    base_cyc = cyc; ovr_cnt_a = 0; n_starts = 0;
  endtask

  task automatic pulse_a();
    trig_a = 1'b1; cycle(); trig_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while (busy_a && n < budget) begin cycle(); n++; end
    chk("a_timeout", busy_a, 0);
  endtask

  task automatic cmp_frame(input string tag, input string got, input string exp);
    chk({tag, "_len"}, got.len(), exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      if (i < got.len()) chk(tag, got[i], exp[i]);
    end
  endtask

  initial begin
    int n;
    crlf = $sformatf("%c%c", 8'h0D, 8'h0A);
    rnd_a = 1'b0; rnd_b = 1'b0; per_mode = 1'b0;
    cyc = 0; prev_busy_a = 1'b0; ovr_cnt_a = 0; n_starts = 0; last_start = 0;
    ch_a = 16'hA355; ch_b = 30'h0;
    rst_n = 1'b0; trig_a = 1'b0; trig_b = 1'b0;
    ifa.tx_ready = 1'b1; ifb.tx_ready = 1'b1;
    cycle(); cycle();
    chk("rst_a_data", ifa.tx_data, 8'h00);
    chk("rst_a_valid", ifa.tx_valid, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_seq", seq_b, 0);
    do_reset();

    // Basic back-to-back frame
    cap_a = "";
    pulse_a();
    wait_idle_a(100);
    cmp_frame("basic", cap_a, {"$00,55,A3", crlf});
    chk("basic_seq", seq_a, 8'd1);

    // Same frame under random backpressure
    do_reset();
    rnd_a = 1'b1; cap_a = "";
    pulse_a();
    wait_idle_a(300);
    rnd_a = 1'b0;
    cmp_frame("bp", cap_a, {"$00,55,A3", crlf});

    // Overrun mid-frame and in the LF-transfer cycle
    do_reset();
    cap_a = "";
    pulse_a();
    repeat (4) cycle();
    pulse_a();
    n = 0;
    while (!(ifa.tx_valid && ifa.tx_data == 8'h0A) && n < 50) begin cycle(); n++; end
    chk("lf_seen", ifa.tx_data, 8'h0A);
    pulse_a();
    repeat (3) cycle();
    chk("ovr_cnt", ovr_cnt_a, 2);
    chk("ovr_idle", busy_a, 0);
    cmp_frame("ovr", cap_a, {"$00,55,A3", crlf});

    // Width/pad on instance B with mid-frame data changes
    ch_b = {10'h12A, 10'h000, 10'h3FF};
    rnd_b = 1'b1; cap_b = "";
    trig_b = 1'b1; cycle(); trig_b = 1'b0;
    repeat (3) cycle();
    ch_b = 30'($urandom);
    n = 0;
    while (busy_b && n < 300) begin cycle(); n++; end
    chk("b_timeout", busy_b, 0);
    rnd_b = 1'b0;
    cmp_frame("pad", cap_b, {"$3FF,000,12A", crlf});
    chk("b_seq", seq_b, 8'd1);

    // Periodic frames with random data and sequence wrap
    do_reset();
    per_mode = 1'b1;
    for (int i = 0; i < 257 * 64 + 20; i++) begin
      ch_a = 16'($urandom);
      cycle();
    end
    per_mode = 1'b0;
    chk("n_frames", n_starts, 257);
    chk("seq_wrap", seq_a, 8'd1);

    // Reset during a digit byte, then a fresh frame
    ch_a = 16'hA355;
    pulse_a();
    repeat (4) cycle();
    chk("rst_pre_dig", ifa.tx_data, 8'h35);
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    chk("rst_mid_valid", ifa.tx_valid, 0);
    chk("rst_mid_busy", busy_a, 0);
    chk("rst_mid_seq", seq_a, 0);
    cap_a = "";
    pulse_a();
    wait_idle_a(100);
    cmp_frame("post_rst", cap_a, {"$00,55,A3", crlf});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
